// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner (master) and the
// keypad pins / downstream debouncer (slave).
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       new_key;

  modport master (
    input  col,
    output row,
    output key_code,
    output key_pressed,
    output new_key
  );

  modport slave (
    output col,
    input  row,
    input  key_code,
    input  key_pressed,
    input  new_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, locks onto one key
// and holds its row until release. Define GHOST_REJECT_EN to ignore multi-column samples.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset,
  keypad_scanner_if.master kp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {SCAN, LOCK} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_meta_q, col_s_q;
  logic [3:0]    row_q, row_rot;
  logic [3:0]    key_code_q, key_d;
  logic          key_pressed_q, new_key_q;
  logic [1:0]    lock_col_q;
  logic [1:0]    row_idx, low_col;
  logic [3:0]    col_low;
  logic          sample, any_low, multi_low, lock_hit;

  // The column pins are asynchronous, so they only enter the logic via two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_q <= 4'b1111;
      col_s_q    <= 4'b1111;
    end else begin
      col_meta_q <= kp.col;
      col_s_q    <= col_meta_q;
    end
  end

  always_comb begin
    sample    = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d     = sample ? '0 : cnt_q + 1'b1;
    row_rot   = {row_q[2:0], row_q[3]};
    col_low   = ~col_s_q;
    any_low   = |col_low;
    multi_low = |(col_low & 4'(col_low - 4'd1));

    row_idx = 2'd0;
    case (row_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase

    if (col_low[0])      low_col = 2'd0;
    else if (col_low[1]) low_col = 2'd1;
    else if (col_low[2]) low_col = 2'd2;
    else                 low_col = 2'd3;

`ifdef GHOST_REJECT_EN
    lock_hit = any_low & ~multi_low;
`else
    lock_hit = any_low;
`endif

    key_d = 4'h0;
    case ({row_idx, low_col})
      4'd0:  key_d = 4'h1;
      4'd1:  key_d = 4'h2;
      4'd2:  key_d = 4'h3;
      4'd3:  key_d = 4'hA;
      4'd4:  key_d = 4'h4;
      4'd5:  key_d = 4'h5;
      4'd6:  key_d = 4'h6;
      4'd7:  key_d = 4'hB;
      4'd8:  key_d = 4'h7;
      4'd9:  key_d = 4'h8;
      4'd10: key_d = 4'h9;
      4'd11: key_d = 4'hC;
      4'd12: key_d = 4'hE;
      4'd13: key_d = 4'h0;
      4'd14: key_d = 4'hF;
      default: key_d = 4'hD;
    endcase
  end

  // Scan/lock FSM; everything is decided only at the end of each dwell period,
  // and on release the row moves on so the same key needs a full rotation to relock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SCAN;
      cnt_q         <= '0;
      row_q         <= 4'b1110;
      key_code_q    <= 4'h0;
      key_pressed_q <= 1'b0;
      new_key_q     <= 1'b0;
      lock_col_q    <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      new_key_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (sample) begin
            if (lock_hit) begin
              state_q       <= LOCK;
              lock_col_q    <= low_col;
              key_code_q    <= key_d;
              key_pressed_q <= 1'b1;
              new_key_q     <= 1'b1;
            end else begin
              row_q <= row_rot;
            end
          end
        end
        LOCK: begin
          if (sample && col_s_q[lock_col_q]) begin
            state_q       <= SCAN;
            key_pressed_q <= 1'b0;
            row_q         <= row_rot;
          end
        end
      endcase
    end
  end

  assign kp.row         = row_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_pressed = key_pressed_q;
  assign kp.new_key     = new_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad matrix model drives the
// columns, and a scoreboard checks every new_key lock against the expected key.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [3:0] row;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  logic [3:0] keyMap [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  logic [15:0] keysDown = '0;
  logic        forceEn = 1'b0;
  logic [3:0]  forceCol = 4'b1111;
  logic [3:0]  matrixCol;

  // A held key shorts its column to its row, so the column reads low only
  // while that key's row is being driven low.
  always_comb begin
    matrixCol = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keysDown[r*4+c] && !kp.row[r]) matrixCol[c] = 1'b0;
  end

  assign kp.col = forceEn ? forceCol : matrixCol;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic down, input logic expectLock);
    exp_t e;
    keysDown[r*4+c] = down;
    if (expectLock) begin
      e.code = keyMap[r][c];
      e.row  = ~(4'b0001 << r);
      expQ.push_back(e);
    end
  endtask

  task automatic waitPressed(input logic level, input int bound, input string name);
    int n = 0;
    while (kp.key_pressed !== level && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, kp.key_pressed}, {31'd0, level});
  endtask

  task automatic waitRow(input logic [3:0] value, input int bound, input string name);
    int n = 0;
    while (kp.row !== value && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {28'd0, kp.row}, {28'd0, value});
  endtask

  // Monitor: every new_key pulse must match the oldest outstanding expectation.
  logic prevNew = 1'b0;
  always @(negedge clk) begin
    if (kp.new_key === 1'b1) begin
      exp_t e;
      checkOutput("newKeyWidth", {31'd0, prevNew}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedNewKey: got code 0x%0h row %b, expected no pulse at %0t",
                 kp.key_code, kp.row, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("lockCode", {28'd0, kp.key_code}, {28'd0, e.code});
        checkOutput("lockRow", {28'd0, kp.row}, {28'd0, e.row});
        checkOutput("lockLevel", {31'd0, kp.key_pressed}, 32'd1);
      end
    end
    prevNew = kp.new_key;
  end

  initial begin
    logic held;
    exp_t e;
    int r, c;

    repeat (3) @(negedge clk);
    checkOutput("resetRow", {28'd0, kp.row}, 32'b1110);
    checkOutput("resetPressed", {31'd0, kp.key_pressed}, 32'd0);
    checkOutput("resetCode", {28'd0, kp.key_code}, 32'h0);
    checkOutput("resetNewKey", {31'd0, kp.new_key}, 32'd0);
    reset = 1'b1;

    repeat (SCAN_DIV - 1) @(negedge clk);
    checkOutput("rowDwellHold", {28'd0, kp.row}, 32'b1110);
    @(negedge clk);
    checkOutput("rowStep1", {28'd0, kp.row}, 32'b1101);
    repeat (SCAN_DIV) @(negedge clk);
    checkOutput("rowStep2", {28'd0, kp.row}, 32'b1011);
    repeat (SCAN_DIV) @(negedge clk);
    checkOutput("rowStep3", {28'd0, kp.row}, 32'b0111);
    repeat (SCAN_DIV) @(negedge clk);
    checkOutput("rowStep4", {28'd0, kp.row}, 32'b1110);

    applyStimulus(1, 1, 1'b1, 1'b1);
    waitPressed(1'b1, 6*SCAN_DIV, "press5");
    checkOutput("press5Code", {28'd0, kp.key_code}, 32'h5);
    held = 1'b1;
    repeat (3*SCAN_DIV) begin
      @(negedge clk);
      if (kp.row !== 4'b1101 || kp.key_pressed !== 1'b1) held = 1'b0;
    end
    checkOutput("press5RowHeld", {31'd0, held}, 32'd1);

    applyStimulus(1, 1, 1'b0, 1'b0);
    waitPressed(1'b0, SCAN_DIV + 3, "release5");
    checkOutput("release5Code", {28'd0, kp.key_code}, 32'h5);
    checkOutput("release5Row", {28'd0, kp.row}, 32'b1011);

    waitRow(4'b1110, 5*SCAN_DIV, "reachRow0");
`ifdef GHOST_REJECT_EN
    applyStimulus(0, 0, 1'b1, 1'b0);
    applyStimulus(0, 2, 1'b1, 1'b0);
    waitRow(4'b1101, SCAN_DIV + 2, "ghostRotate");
    checkOutput("ghostNoLock", {31'd0, kp.key_pressed}, 32'd0);
    applyStimulus(0, 0, 1'b0, 1'b0);
    applyStimulus(0, 2, 1'b0, 1'b0);
`else
    applyStimulus(0, 0, 1'b1, 1'b1);
    applyStimulus(0, 2, 1'b1, 1'b0);
    waitPressed(1'b1, SCAN_DIV + 2, "multiLock");
    checkOutput("multiCode", {28'd0, kp.key_code}, 32'h1);
    applyStimulus(0, 0, 1'b0, 1'b0);
    applyStimulus(0, 2, 1'b0, 1'b0);
    waitPressed(1'b0, SCAN_DIV + 3, "multiRelease");
`endif

    waitRow(4'b1110, 5*SCAN_DIV, "glitchRow0");
    forceCol = 4'b1110;
    forceEn  = 1'b1;
    repeat (3) @(negedge clk);
    forceEn  = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("glitchNoLock", {31'd0, kp.key_pressed}, 32'd0);
    checkOutput("glitchRotate", {28'd0, kp.row}, 32'b1101);

    applyStimulus(3, 1, 1'b1, 1'b1);
    waitPressed(1'b1, 6*SCAN_DIV, "lock0");
    checkOutput("lock0Row", {28'd0, kp.row}, 32'b0111);
    e.code = 4'h0;
    e.row  = 4'b0111;
    expQ.push_back(e);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midResetRow", {28'd0, kp.row}, 32'b1110);
    checkOutput("midResetPressed", {31'd0, kp.key_pressed}, 32'd0);
    checkOutput("midResetCode", {28'd0, kp.key_code}, 32'h0);
    checkOutput("midResetNewKey", {31'd0, kp.new_key}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    waitPressed(1'b1, 6*SCAN_DIV, "relock0");
    checkOutput("relock0Row", {28'd0, kp.row}, 32'b0111);
    applyStimulus(3, 1, 1'b0, 1'b0);
    waitPressed(1'b0, SCAN_DIV + 3, "release0");

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      applyStimulus(r, c, 1'b1, 1'b1);
      waitPressed(1'b1, 5*SCAN_DIV + 4, "rndLock");
      repeat ($urandom_range(0, 20)) @(negedge clk);
      applyStimulus(r, c, 1'b0, 1'b0);
      waitPressed(1'b0, SCAN_DIV + 3, "rndRelease");
      checkOutput("rndHoldCode", {28'd0, kp.key_code}, {28'd0, keyMap[r][c]});
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
